serial_readout_receiver: RTL and testbench

//  Receive end of the AE serial readout link. Deserializes one frame per acoustic event:
//  an RTC timestamp word followed by channel-memory data words. Outputs each word in

---
 rtl/serial_readout_pkg.sv | 19 +
 rtl/sr_deser.sv | 37 +++
 rtl/serial_readout_receiver.sv | 150 +++++++++++++++
 tb/tb_serial_readout_receiver.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_readout_pkg.sv
// Shared definitions for the AE serial readout link: FSM states, default frame
// geometry and bit_sel encodings common to the transmitter and receiver.
package serial_readout_pkg;

  localparam int RTC_W_DEF     = 30;
  localparam int DATA_W_DEF    = 3;
  localparam int MAX_WORDS_DEF = 200;

  localparam logic SEL_RTC  = 1'b0;
  localparam logic SEL_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RTC   = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } sr_state_t;

endpackage

// File: rtl/sr_deser.sv
// MSB-first deserializer: shifts bit_in on shift_en and flags the shift that
// completes a W-bit word; `word` is the assembled value on that same cycle.
module sr_deser #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         shift_en,
  input  logic         bit_in,
  output logic [W-1:0] word,
  output logic         full
);

  localparam int CNT_W = $clog2(W);

  logic [W-2:0]     sh_q;
  logic [CNT_W-1:0] cnt_q;

  assign word = {sh_q, bit_in};
  assign full = shift_en && !clear && (cnt_q == CNT_W'(W - 1));

  // clear may coincide with the first bit of a new frame, which then becomes bit 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      sh_q  <= shift_en ? (W-1)'(bit_in) : '0;
      cnt_q <= shift_en ? CNT_W'(1) : '0;
    end else if (shift_en) begin
      sh_q  <= word[W-2:0];
      cnt_q <= full ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_readout_receiver.sv
// Receive end of the AE serial readout link: splits each frame into an RTC
// timestamp and channel-memory words, with per-word strobes and frame status.
module serial_readout_receiver
  import serial_readout_pkg::*;
#(
  parameter int RTC_W     = RTC_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_active,
  input  logic              bit_valid,
  input  logic              bit_sel,
  input  logic              bit_in,
  output logic [RTC_W-1:0]  rtc_word,
  output logic              rtc_valid,
  output logic [DATA_W-1:0] data_word,
  output logic              data_valid,
  output logic [7:0]        word_idx,
  output logic              frame_done,
  output logic [7:0]        word_count,
  output logic              frame_error
);

  sr_state_t         state_q, state_n, cur;
  logic              fa_q;
  logic              rise, start, bit_ok, at_limit;
  logic              rtc_shift, data_shift, rtc_full, data_full;
  logic [RTC_W-1:0]  rtc_asm;
  logic [DATA_W-1:0] data_asm;
  logic [7:0]        word_cnt_q, word_cnt_n;
  logic              part_q, part_n;
  logic              err_n, done_n;

  assign rise     = frame_active && !fa_q;
  assign start    = (state_q == IDLE) && rise;
  // the rising-edge cycle already belongs to the RTC phase
  assign cur      = start ? RTC : state_q;
  assign bit_ok   = frame_active && bit_valid;
  assign at_limit = (word_cnt_q == 8'(MAX_WORDS));

  assign rtc_shift  = (cur == RTC) && bit_ok && (bit_sel == SEL_RTC);
  assign data_shift = (cur == DATA) && bit_ok && (bit_sel == SEL_DATA) && !at_limit;

  sr_deser #(.W(RTC_W)) u_rtc_deser (
    .clk      (clk),
    .reset    (reset),
    .clear    (start),
    .shift_en (rtc_shift),
    .bit_in   (bit_in),
    .word     (rtc_asm),
    .full     (rtc_full)
  );

  sr_deser #(.W(DATA_W)) u_data_deser (
    .clk      (clk),
    .reset    (reset),
    .clear    (start),
    .shift_en (data_shift),
    .bit_in   (bit_in),
    .word     (data_asm),
    .full     (data_full)
  );

  // fa_q resets high so a frame_active already high at reset release is not a start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fa_q       <= 1'b1;
      word_cnt_q <= '0;
      part_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      fa_q       <= frame_active;
      word_cnt_q <= word_cnt_n;
      part_q     <= part_n;
    end
  end

  always_comb begin
    state_n    = cur;
    word_cnt_n = start ? 8'd0 : word_cnt_q;
    part_n     = start ? 1'b0 : part_q;
    err_n      = start ? 1'b0 : frame_error;
    done_n     = 1'b0;

    if (cur != IDLE && !frame_active) begin
      state_n = IDLE;
      done_n  = 1'b1;
      // an unfinished timestamp or data word at frame end is discarded and flagged
      if (cur == RTC || (cur == DATA && part_q))
        err_n = 1'b1;
    end else begin
      unique case (cur)
        RTC: begin
          if (bit_ok) begin
            if (bit_sel != SEL_RTC) begin
              err_n   = 1'b1;
              state_n = DRAIN;
            end else if (rtc_full) begin
              state_n = DATA;
            end
          end
        end
        DATA: begin
          if (bit_ok) begin
            if (!data_shift) begin
              err_n   = 1'b1;
              state_n = DRAIN;
            end else if (data_full) begin
              word_cnt_n = word_cnt_q + 8'd1;
              part_n     = 1'b0;
            end else begin
              part_n = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rtc_word    <= '0;
      rtc_valid   <= 1'b0;
      data_word   <= '0;
      data_valid  <= 1'b0;
      word_idx    <= '0;
      frame_done  <= 1'b0;
      word_count  <= '0;
      frame_error <= 1'b0;
    end else begin
      rtc_valid   <= rtc_full;
      data_valid  <= data_full;
      frame_done  <= done_n;
      frame_error <= err_n;
      if (rtc_full)
        rtc_word <= rtc_asm;
      if (data_full) begin
        data_word <= data_asm;
        word_idx  <= word_cnt_q;
      end
      if (done_n)
        word_count <= word_cnt_q;
    end
  end

endmodule

// File: tb/tb_serial_readout_receiver.sv
// Bench for serial_readout_receiver: directed frames as cycle vectors, a frame-level
// reference scan producing expected strobes per cycle, and literal per-test expectations.
module tb_serial_readout_receiver;

  localparam int RTC_W     = 30;
  localparam int DATA_W    = 3;
  localparam int MAX_WORDS = 200;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              frame_active = 1'b0;
  logic              bit_valid = 1'b0;
  logic              bit_sel = 1'b0;
  logic              bit_in = 1'b0;
  logic [RTC_W-1:0]  rtc_word;
  logic              rtc_valid;
  logic [DATA_W-1:0] data_word;
  logic              data_valid;
  logic [7:0]        word_idx;
  logic              frame_done;
  logic [7:0]        word_count;
  logic              frame_error;

  serial_readout_receiver #(
    .RTC_W     (RTC_W),
    .DATA_W    (DATA_W),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_active (frame_active),
    .bit_valid    (bit_valid),
    .bit_sel      (bit_sel),
    .bit_in       (bit_in),
    .rtc_word     (rtc_word),
    .rtc_valid    (rtc_valid),
    .data_word    (data_word),
    .data_valid   (data_valid),
    .word_idx     (word_idx),
    .frame_done   (frame_done),
    .word_count   (word_count),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Stimulus as one entry per clock cycle
  logic vf[$], vv[$], vs[$], vb[$];
  int   gap_pat[8] = '{0, 1, 0, 2, 0, 0, 3, 1};
  int   gidx = 0;
  logic [DATA_W-1:0] wv[$];

  // Expected events keyed by the cycle they must be visible in
  logic [RTC_W-1:0]  exp_rtc[int];
  logic [7+DATA_W:0] exp_data[int];
  logic [7:0]        exp_done[int];
  bit                exp_eset[int];
  bit                exp_eclr[int];

  task automatic push_vec(input logic fa, input logic bv, input logic sel, input logic b);
    vf.push_back(fa);
    vv.push_back(bv);
    vs.push_back(sel);
    vb.push_back(b);
  endtask

  task automatic add_bit(input int gaps, input logic sel, input logic b);
    if (gaps != 0) begin
      for (int j = 0; j < gap_pat[gidx % 8]; j++) push_vec(1'b1, 1'b0, gidx[0], 1'b1);
      gidx++;
    end
    push_vec(1'b1, 1'b1, sel, b);
  endtask

  task automatic build_frame(input logic [RTC_W-1:0] rtc, input int nwords, input int gaps,
                             input int bad_rtc_bit, input int extra_bits, input int drop_last,
                             input int close);
    push_vec(1'b0, 1'b0, 1'b0, 1'b0);
    push_vec(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < RTC_W; k++) add_bit(gaps, (k == bad_rtc_bit), rtc[RTC_W-1-k]);
    for (int w = 0; w < nwords; w++)
      for (int b = 0; b < DATA_W; b++) add_bit(gaps, 1'b1, wv[w][DATA_W-1-b]);
    for (int p = 0; p < extra_bits; p++) add_bit(gaps, 1'b1, p[0]);
    if (drop_last != 0) vf[vf.size()-1] = 1'b0;
    if (close != 0) begin
      repeat (3) push_vec(1'b0, 1'b0, 1'b0, 1'b0);
    end else begin
      repeat (2) push_vec(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Reference: walk the sampled bit stream of each frame and derive its events
  task automatic model(input int base, input logic init_prev);
    logic prev, in_frame, stopped;
    int nrtc, part, words, c;
    logic [RTC_W-1:0]  racc;
    logic [DATA_W-1:0] dacc;
    prev = init_prev; in_frame = 1'b0; stopped = 1'b0;
    nrtc = 0; part = 0; words = 0; racc = '0; dacc = '0;
    for (int i = 0; i < vf.size(); i++) begin
      c = base + i;
      if (!in_frame) begin
        if (vf[i] && !prev) begin
          in_frame = 1'b1; stopped = 1'b0;
          nrtc = 0; part = 0; words = 0; racc = '0; dacc = '0;
          exp_eclr[c+1] = 1'b1;
        end
      end else if (!vf[i]) begin
        in_frame = 1'b0;
        if (!stopped && (nrtc < RTC_W || part != 0)) exp_eset[c+1] = 1'b1;
        exp_done[c+1] = words[7:0];
      end
      if (in_frame && vv[i] && !stopped) begin
        if (nrtc < RTC_W) begin
          if (vs[i] != 1'b0) begin
            stopped = 1'b1;
            exp_eset[c+1] = 1'b1;
          end else begin
            racc = {racc[RTC_W-2:0], vb[i]};
            nrtc++;
            if (nrtc == RTC_W) exp_rtc[c+1] = racc;
          end
        end else if (vs[i] != 1'b1 || words == MAX_WORDS) begin
          stopped = 1'b1;
          exp_eset[c+1] = 1'b1;
        end else begin
          dacc = {dacc[DATA_W-2:0], vb[i]};
          part++;
          if (part == DATA_W) begin
            exp_data[c+1] = {words[7:0], dacc};
            words++;
            part = 0;
          end
        end
      end
      prev = vf[i];
    end
  endtask

  task automatic run_vectors(input logic init_prev);
    int base;
    base = cyc + 1;
    model(base, init_prev);
    for (int i = 0; i < vf.size(); i++) begin
      @(posedge clk);
      #1;
      frame_active = vf[i];
      bit_valid    = vv[i];
      bit_sel      = vs[i];
      bit_in       = vb[i];
    end
    vf.delete(); vv.delete(); vs.delete(); vb.delete();
    gidx = 0;
  endtask

  // Observations gathered per test for the literal expectations
  int               n_rtc, n_data, n_done, last_idx, last_wc;
  logic [RTC_W-1:0] last_rtc;
  logic             last_err;
  logic [DATA_W-1:0] obs_data[$];

  task automatic clear_obs();
    n_rtc = 0; n_data = 0; n_done = 0; last_idx = -1; last_wc = -1;
    last_rtc = '0; last_err = 1'b0;
    obs_data.delete();
  endtask

  logic             err_lvl = 1'b0;
  logic [RTC_W-1:0] hold = '0;

  always @(negedge clk) begin
    if (reset) begin
      err_lvl = 1'b0;
      hold    = '0;
      check("reset_outputs", {rtc_word, rtc_valid, data_word, data_valid, word_idx,
                              frame_done, word_count, frame_error}, 64'd0);
    end else begin
      if (exp_eclr.exists(cyc)) err_lvl = 1'b0;
      if (exp_eset.exists(cyc)) err_lvl = 1'b1;
      if (exp_rtc.exists(cyc)) hold = exp_rtc[cyc];
      check("rtc_valid", rtc_valid, exp_rtc.exists(cyc));
      check("rtc_word", rtc_word, hold);
      check("data_valid", data_valid, exp_data.exists(cyc));
      if (data_valid && exp_data.exists(cyc))
        check("data_word_idx", {word_idx, data_word}, exp_data[cyc]);
      check("frame_done", frame_done, exp_done.exists(cyc));
      if (frame_done && exp_done.exists(cyc))
        check("word_count", word_count, exp_done[cyc]);
      check("frame_error", frame_error, err_lvl);
      if (rtc_valid) begin n_rtc++; last_rtc = rtc_word; end
      if (data_valid) begin n_data++; last_idx = word_idx; obs_data.push_back(data_word); end
      if (frame_done) begin n_done++; last_wc = word_count; last_err = frame_error; end
    end
  end

  task automatic expect_basic(input string tag);
    check({tag, "_n_rtc"}, n_rtc, 1);
    check({tag, "_rtc"}, last_rtc, 30'h2AAAAAAA);
    check({tag, "_n_data"}, n_data, 3);
    check({tag, "_w0"}, obs_data[0], 3'b101);
    check({tag, "_w1"}, obs_data[1], 3'b010);
    check({tag, "_w2"}, obs_data[2], 3'b111);
    check({tag, "_last_idx"}, last_idx, 2);
    check({tag, "_n_done"}, n_done, 1);
    check({tag, "_word_count"}, last_wc, 3);
    check({tag, "_error"}, last_err, 1'b0);
  endtask

  initial begin
    clear_obs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_rel_frame_done", frame_done, 1'b0);
    check("rst_rel_rtc_word", rtc_word, 30'd0);

    // contiguous frame
    wv = {3'b101, 3'b010, 3'b111};
    clear_obs();
    build_frame(30'h2AAAAAAA, 3, 0, -1, 0, 0, 1);
    run_vectors(1'b0);
    expect_basic("t1");

    // same frame with bit_valid gaps, including inside words
    clear_obs();
    build_frame(30'h2AAAAAAA, 3, 1, -1, 0, 0, 1);
    run_vectors(1'b0);
    expect_basic("t2");

    // 201 words: the last one overflows the bank depth
    wv.delete();
    for (int i = 0; i < 201; i++) wv.push_back(DATA_W'(i % 8));
    clear_obs();
    build_frame(30'h12345678, 201, 0, -1, 0, 0, 1);
    run_vectors(1'b0);
    check("t3_n_data", n_data, 200);
    check("t3_last_idx", last_idx, 199);
    check("t3_word_count", last_wc, 200);
    check("t3_error", last_err, 1'b1);

    // frame ends 2 bits into word 5
    clear_obs();
    build_frame(30'h00000001, 5, 0, -1, 2, 0, 1);
    run_vectors(1'b0);
    check("t4_n_data", n_data, 5);
    check("t4_word_count", last_wc, 5);
    check("t4_error", last_err, 1'b1);

    // data-select bit at RTC bit 10
    clear_obs();
    build_frame(30'h3FFFFFFF, 3, 0, 10, 0, 0, 1);
    run_vectors(1'b0);
    check("t5_n_rtc", n_rtc, 0);
    check("t5_n_data", n_data, 0);
    check("t5_word_count", last_wc, 0);
    check("t5_error", last_err, 1'b1);

    // reset in DATA after 50 words, frame_active still high at release
    clear_obs();
    build_frame(30'h0ABCDEF0, 50, 0, -1, 0, 0, 0);
    run_vectors(1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check("t6_reset_rtc_word", rtc_word, 30'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) push_vec(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (2) push_vec(1'b0, 1'b0, 1'b0, 1'b0);
    run_vectors(1'b1);
    check("t6_n_data", n_data, 50);
    check("t6_last_idx", last_idx, 49);
    check("t6_n_done", n_done, 0);
    check("t6_n_rtc", n_rtc, 1);
    wv = {3'b101, 3'b010, 3'b111};
    clear_obs();
    build_frame(30'h2AAAAAAA, 3, 0, -1, 0, 0, 1);
    run_vectors(1'b0);
    expect_basic("t6b");

    // frame with no data words
    clear_obs();
    build_frame(30'h15555555, 0, 0, -1, 0, 0, 1);
    run_vectors(1'b0);
    check("t7_n_rtc", n_rtc, 1);
    check("t7_rtc", last_rtc, 30'h15555555);
    check("t7_word_count", last_wc, 0);
    check("t7_error", last_err, 1'b0);

    // last bit arrives in the cycle frame_active falls
    clear_obs();
    build_frame(30'h2AAAAAAA, 2, 0, -1, 0, 1, 1);
    run_vectors(1'b0);
    check("t8_n_data", n_data, 1);
    check("t8_word_count", last_wc, 1);
    check("t8_error", last_err, 1'b1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
